spectrum_peak_search: RTL and testbench

- Second stage after the magnitude stage.
- When the magnitude RAM is full (write-done level from the magnitude stage), the block sweeps the single-sided spectrum once through the RAM read port.
- It finds the two largest local maxima above a threshold and reports their bin indices and magnitudes to the signal-separation/identification logic.
- One sweep per start edge. The start key re-arms the block in the same way as the rest of the chain.

---
 rtl/spectrum_peak_search.sv | 213 +++++++++++++++++++++
 tb/tb_spectrum_peak_search.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spectrum_peak_search.sv
// Sweeps the magnitude RAM once per start edge and reports the two
// largest local maxima (bin, mag) above THRESH; key=0 restarts.
module spectrum_peak_search #(
  parameter int              FIRST_BIN = 1,
  parameter int              LAST_BIN  = 128,
  parameter int              MAG_W     = 16,
  parameter int              ADDR_W    = 8,
  parameter logic [MAG_W-1:0] THRESH   = 16'd8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key,
  input  logic              start,
  input  logic [MAG_W-1:0]  rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] peak1_bin,
  output logic [MAG_W-1:0]  peak1_mag,
  output logic [ADDR_W-1:0] peak2_bin,
  output logic [MAG_W-1:0]  peak2_mag
);

  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_BIN);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_BIN);

  typedef enum logic [1:0] {
    IDLE, READ, DRAIN, DONE
  } state_t;

  state_t state_q, state_d;
  logic start_q, start_d;
  logic rd_en_q, rd_en_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic vld_q, vld_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] dat_bin_q, dat_bin_d;
  logic [ADDR_W-1:0] cur_bin_q, cur_bin_d;
  logic [MAG_W-1:0]  prev_q, prev_d;
  logic [MAG_W-1:0]  cur_q, cur_d;
  logic [ADDR_W-1:0] w1_bin_q, w1_bin_d;
  logic [MAG_W-1:0]  w1_mag_q, w1_mag_d;
  logic [ADDR_W-1:0] w2_bin_q, w2_bin_d;
  logic [MAG_W-1:0]  w2_mag_q, w2_mag_d;
  logic [ADDR_W-1:0] p1_bin_q, p1_bin_d;
  logic [MAG_W-1:0]  p1_mag_q, p1_mag_d;
  logic [ADDR_W-1:0] p2_bin_q, p2_bin_d;
  logic [MAG_W-1:0]  p2_mag_q, p2_mag_d;
  logic is_pk;

  // rd_data acts as the "next" slot of the window, so bin k is
  // judged in the cycle its successor's data is on the bus.
  assign is_pk = vld_q
    && (cur_bin_q > FIRST_A) && (cur_bin_q < LAST_A)
    && (prev_q < cur_q) && (cur_q >= rd_data)
    && (cur_q >= THRESH);

  always_comb begin
    state_d   = state_q;
    start_d   = start;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    vld_d     = rd_en_q;
    dat_bin_d = rd_addr_q;
    cur_bin_d = cur_bin_q;
    prev_d    = prev_q;
    cur_d     = cur_q;
    w1_bin_d  = w1_bin_q;
    w1_mag_d  = w1_mag_q;
    w2_bin_d  = w2_bin_q;
    w2_mag_d  = w2_mag_q;
    p1_bin_d  = p1_bin_q;
    p1_mag_d  = p1_mag_q;
    p2_bin_d  = p2_bin_q;
    p2_mag_d  = p2_mag_q;

    if (vld_q) begin
      prev_d    = cur_q;
      cur_d     = rd_data;
      cur_bin_d = dat_bin_q;
    end

    if (is_pk) begin
      if (cur_q > w1_mag_q) begin
        w2_bin_d = w1_bin_q;
        w2_mag_d = w1_mag_q;
        w1_bin_d = cur_bin_q;
        w1_mag_d = cur_q;
      end else if (cur_q > w2_mag_q) begin
        w2_bin_d = cur_bin_q;
        w2_mag_d = cur_q;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (start && !start_q) begin
          state_d   = READ;
          rd_en_d   = 1'b1;
          busy_d    = 1'b1;
          rd_addr_d = FIRST_A;
          prev_d    = '0;
          cur_d     = '0;
          cur_bin_d = '0;
          w1_bin_d  = '0;
          w1_mag_d  = '0;
          w2_bin_d  = '0;
          w2_mag_d  = '0;
        end
      end
      READ: begin
        if (rd_addr_q == LAST_A) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // Publish including this cycle's final evaluation.
        state_d  = DONE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        p1_bin_d = w1_bin_d;
        p1_mag_d = w1_mag_d;
        p2_bin_d = w2_bin_d;
        p2_mag_d = w2_mag_d;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (!key) begin
      state_d   = IDLE;
      start_d   = 1'b0;
      rd_en_d   = 1'b0;
      rd_addr_d = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      vld_d     = 1'b0;
      dat_bin_d = '0;
      cur_bin_d = '0;
      prev_d    = '0;
      cur_d     = '0;
      w1_bin_d  = '0;
      w1_mag_d  = '0;
      w2_bin_d  = '0;
      w2_mag_d  = '0;
      p1_bin_d  = '0;
      p1_mag_d  = '0;
      p2_bin_d  = '0;
      p2_mag_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_q     <= 1'b0;
      dat_bin_q <= '0;
      cur_bin_q <= '0;
      prev_q    <= '0;
      cur_q     <= '0;
      w1_bin_q  <= '0;
      w1_mag_q  <= '0;
      w2_bin_q  <= '0;
      w2_mag_q  <= '0;
      p1_bin_q  <= '0;
      p1_mag_q  <= '0;
      p2_bin_q  <= '0;
      p2_mag_q  <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      vld_q     <= vld_d;
      dat_bin_q <= dat_bin_d;
      cur_bin_q <= cur_bin_d;
      prev_q    <= prev_d;
      cur_q     <= cur_d;
      w1_bin_q  <= w1_bin_d;
      w1_mag_q  <= w1_mag_d;
      w2_bin_q  <= w2_bin_d;
      w2_mag_q  <= w2_mag_d;
      p1_bin_q  <= p1_bin_d;
      p1_mag_q  <= p1_mag_d;
      p2_bin_q  <= p2_bin_d;
      p2_mag_q  <= p2_mag_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign peak1_bin = p1_bin_q;
  assign peak1_mag = p1_mag_q;
  assign peak2_bin = p2_bin_q;
  assign peak2_mag = p2_mag_q;

endmodule

// File: tb/tb_spectrum_peak_search.sv
// Directed bench for spectrum_peak_search with a 1-cycle RAM model.
// Ports: drives clk/rst_n/key/start/rd_data, checks all outputs.
module tb_spectrum_peak_search;

  logic        clk = 1'b0;
  logic        rst_n, key, start;
  logic [15:0] rd_data = '0;
  logic        rd_en, busy, done;
  logic [7:0]  rd_addr, peak1_bin, peak2_bin;
  logic [15:0] peak1_mag, peak2_mag;
  logic [15:0] mem [0:255];
  int          total = 0;
  int          passes = 0;

  spectrum_peak_search dut (
    .clk(clk), .rst_n(rst_n), .key(key), .start(start),
    .rd_data(rd_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .busy(busy), .done(done),
    .peak1_bin(peak1_bin), .peak1_mag(peak1_mag),
    .peak2_bin(peak2_bin), .peak2_mag(peak2_mag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic outs(input string nm, input int b1, input int m1,
                      input int b2, input int m2);
    check({nm, "_p1b"}, int'(peak1_bin), b1);
    check({nm, "_p1m"}, int'(peak1_mag), m1);
    check({nm, "_p2b"}, int'(peak2_bin), b2);
    check({nm, "_p2m"}, int'(peak2_mag), m2);
  endtask

  task automatic sweep(input string nm, input int b1, input int m1,
                       input int b2, input int m2, input bit tog);
    int n;
    int lat;
    bit ok;
    @(negedge clk);
    start = 1'b1;
    n = 0;
    while (!rd_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_rd_en_rise"}, int'(rd_en), 1);
    lat = 0;
    ok = 1'b1;
    while (!done && lat < 300) begin
      if (lat < 128) begin
        if (!rd_en || !busy || rd_addr != 8'(lat + 1)) ok = 1'b0;
      end else if (rd_en || !busy) ok = 1'b0;
      if (tog && lat == 50) start = 1'b0;
      if (tog && lat == 52) start = 1'b1;
      @(negedge clk);
      lat++;
    end
    check({nm, "_latency"}, lat, 129);
    check({nm, "_rd_seq"}, int'(ok), 1);
    check({nm, "_busy_at_done"}, int'(busy), 0);
    outs(nm, b1, m1, b2, m2);
    @(negedge clk);
    check({nm, "_done_1cyc"}, int'(done), 0);
    check({nm, "_addr_hold"}, int'(rd_addr), 128);
  endtask

  task automatic gap();
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic three_peaks();
    fill(16'd0);
    mem[10] = 16'd200;
    mem[60] = 16'd900;
    mem[90] = 16'd400;
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    key   = 1'b1;
    start = 1'b1;
    fill(16'd0);
    #23;
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(rd_addr), 0);
    outs("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    sweep("zeros", 0, 0, 0, 0, 1'b0);
    gap();

    fill(16'd2);
    mem[19] = 16'd100; mem[20] = 16'd500; mem[21] = 16'd100;
    mem[44] = 16'd50;  mem[45] = 16'd300; mem[46] = 16'd50;
    sweep("two", 20, 500, 45, 300, 1'b0);
    gap();

    three_peaks();
    sweep("three", 60, 900, 90, 400, 1'b0);
    gap();

    fill(16'd0);
    mem[1] = 16'd1000; mem[128] = 16'd1000;
    mem[30] = 16'd250; mem[31] = 16'd250;
    mem[70] = 16'd600; mem[80] = 16'd600;
    mem[50] = 16'd7;
    sweep("edge_tie", 70, 600, 80, 600, 1'b0);
    gap();

    fill(16'd0);
    mem[30] = 16'd250; mem[31] = 16'd250;
    mem[50] = 16'd7;
    sweep("flat_one", 30, 250, 0, 0, 1'b0);
    gap();

    three_peaks();
    sweep("pre_abort", 60, 900, 90, 400, 1'b0);
    gap();
    start = 1'b1;
    cnt = 0;
    while (!rd_en && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    repeat (39) @(negedge clk);
    check("abort_mid_read", int'(rd_en), 1);
    key = 1'b0;
    @(negedge clk);
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_addr", int'(rd_addr), 0);
    outs("abort", 0, 0, 0, 0);
    cnt = 0;
    repeat (150) begin
      @(negedge clk);
      if (done || rd_en) cnt++;
    end
    check("abort_no_done", cnt, 0);
    start = 1'b0;
    @(negedge clk);
    key = 1'b1;
    repeat (2) @(negedge clk);
    sweep("post_abort", 60, 900, 90, 400, 1'b0);
    gap();

    sweep("retrig", 60, 900, 90, 400, 1'b1);
    cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (rd_en || busy || done) cnt++;
    end
    check("held_no_resweep", cnt, 0);
    gap();
    sweep("second", 60, 900, 90, 400, 1'b0);
    gap();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
